// File: rtl/serial_negate_pkg.sv
// Shared mode encodings and the per-word invert decision for the serial two's-complement unit.
package serial_negate_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS = 2'b00;
  localparam mode_t MODE_NEG  = 2'b01;
  localparam mode_t MODE_ABS  = 2'b10;

  // Reserved encoding 2'b11 behaves as pass.
  function automatic logic invert_decision(input mode_t mode, input logic sign);
    case (mode)
      MODE_NEG: return 1'b1;
      MODE_ABS: return sign;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_negate_lane.sv
// One serial lane: input word buffer, output shift register and serial negate/overflow logic.
module serial_negate_lane
  import serial_negate_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic  clk,
  input  logic  n_reset,
  input  logic  accept,
  input  logic  load,
  input  logic  advance,
  input  logic  last_next,
  input  mode_t mode,
  input  logic  in_bit,
  output logic  out_bit,
  output logic  out_ovf
);

  logic [WORD_W-2:0] ibuf;
  logic [WORD_W-1:0] word;
  logic [WORD_W-2:0] sreg;
  logic              invert;
  logic              seen_one;

  // Shifting in from the MSB end leaves a full word aligned after WORD_W
  // accepted bits, so a restarted (discarded) word needs no explicit clear.
  assign word = {in_bit, ibuf};

  always_ff @(posedge clk) begin
    if (n_reset) begin
      ibuf     <= '0;
      sreg     <= '0;
      invert   <= 1'b0;
      seen_one <= 1'b0;
      out_bit  <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      if (accept) ibuf <= word[WORD_W-1:1];

      if (load) begin
        sreg     <= word[WORD_W-1:1];
        invert   <= invert_decision(mode, in_bit);
        seen_one <= word[0];
        out_bit  <= word[0];
        out_ovf  <= 1'b0;
      end else if (advance) begin
        sreg     <= sreg >> 1;
        seen_one <= seen_one | sreg[0];
        out_bit  <= sreg[0] ^ (invert & seen_one);
        // Most-negative word: no 1 below the MSB, MSB set.
        out_ovf  <= last_next & invert & ~seen_one & sreg[0];
      end else begin
        seen_one <= 1'b0;
        out_bit  <= 1'b0;
        out_ovf  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_negate_mc.sv
// Multi-channel word-framed bit-serial pass/negate/abs unit with shared framing and output sequencing.
module serial_negate_mc
  import serial_negate_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WORD_W   = 8
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic [CHANNELS-1:0] in_bit,
  input  logic [1:0]          mode,
  output logic                out_valid,
  output logic                out_first,
  output logic                out_last,
  output logic [CHANNELS-1:0] out_bit,
  output logic [CHANNELS-1:0] out_ovf,
  output logic                frame_err
);

  localparam int unsigned    CW       = $clog2(WORD_W);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WORD_W - 1);
  localparam logic [CW-1:0]  PRE_LAST = CW'(WORD_W - 2);

  typedef enum logic {IN_IDLE, IN_WORD} in_state_t;

  in_state_t     in_state;
  logic [CW-1:0] icnt;
  logic [CW-1:0] ocnt;
  mode_t         mode_q;

  logic accept;
  logic load;
  logic advance;
  logic last_next;

  assign accept    = in_valid & (in_first | (in_state == IN_WORD));
  assign load      = in_valid & ~in_first & (in_state == IN_WORD) & (icnt == LAST_BIT);
  // A new load takes priority so a word arriving on out_last chains directly.
  assign advance   = out_valid & ~out_last & ~load;
  assign last_next = advance & (ocnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (n_reset) begin
      in_state  <= IN_IDLE;
      icnt      <= '0;
      ocnt      <= '0;
      mode_q    <= MODE_PASS;
      frame_err <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      frame_err <= in_valid & in_first & (in_state == IN_WORD);

      if (in_valid) begin
        if (in_first) begin
          in_state <= IN_WORD;
          icnt     <= CW'(1);
          mode_q   <= mode;
        end else if (in_state == IN_WORD) begin
          if (icnt == LAST_BIT) begin
            in_state <= IN_IDLE;
            icnt     <= '0;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
      end

      if (load) begin
        out_valid <= 1'b1;
        out_first <= 1'b1;
        out_last  <= 1'b0;
        ocnt      <= '0;
      end else if (advance) begin
        out_first <= 1'b0;
        out_last  <= last_next;
        ocnt      <= ocnt + 1'b1;
      end else begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
        ocnt      <= '0;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    serial_negate_lane #(.WORD_W(WORD_W)) u_lane (
      .clk       (clk),
      .n_reset   (n_reset),
      .accept    (accept),
      .load      (load),
      .advance   (advance),
      .last_next (last_next),
      .mode      (mode_q),
      .in_bit    (in_bit[i]),
      .out_bit   (out_bit[i]),
      .out_ovf   (out_ovf[i])
    );
  end

endmodule

// File: tb/tb_serial_negate_mc.sv
// Directed bench for serial_negate_mc with a word-level arithmetic model and per-cycle output compare.
module tb_serial_negate_mc;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_first = 1'b0;
  logic [3:0] in_bit = '0;
  logic [1:0] mode = '0;
  logic       out_valid, out_first, out_last, frame_err;
  logic [3:0] out_bit, out_ovf;

  serial_negate_mc #(.CHANNELS(4), .WORD_W(8)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_bit    (in_bit),
    .mode      (mode),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .out_bit   (out_bit),
    .out_ovf   (out_ovf),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] val;
    logic [3:0]      ovf;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            cur;
  int unsigned     n_vec = 0;
  int unsigned     n_fail = 0;
  logic            rst_sampled;
  bit              in_word = 0;
  int unsigned     idx = 0;
  logic [3:0][7:0] got_word;
  logic [3:0][7:0] last_word = '0;
  logic [3:0]      last_ovf = '0;
  int unsigned     words_out = 0;
  int unsigned     fe_count = 0;
  int unsigned     run_len = 0;
  int unsigned     max_run = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Word-level model: plain two's-complement arithmetic per lane.
  function automatic exp_t model(input logic [3:0][7:0] w, input logic [1:0] m);
    exp_t e;
    for (int unsigned l = 0; l < 4; l++) begin
      logic inv;
      inv = (m == 2'b01) || (m == 2'b10 && w[l][7]);
      e.val[l] = inv ? 8'(-w[l]) : w[l];
      e.ovf[l] = inv && (w[l] == 8'h80);
    end
    return e;
  endfunction

  always @(posedge clk) rst_sampled <= n_reset;

  always @(negedge clk) begin
    if (rst_sampled === 1'b1) begin
      check("reset_outputs", {out_valid, out_first, out_last, out_bit, out_ovf, frame_err}, 32'h0);
      exp_q.delete();
      in_word = 0;
      run_len = 0;
    end else if (rst_sampled === 1'b0) begin
      if (frame_err) fe_count++;
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else run_len = 0;

      if (out_valid && out_first) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_word: got out_first with no word pending at %0t", $time);
        end else begin
          cur = exp_q.pop_front();
          in_word = 1;
          idx = 0;
        end
      end

      if (in_word) begin
        logic [3:0] eb;
        for (int unsigned l = 0; l < 4; l++) eb[l] = cur.val[l][idx];
        check("valid_contig", out_valid, 1);
        check("out_bit", out_bit, eb);
        check("out_first", out_first, idx == 0);
        check("out_last", out_last, idx == 7);
        check("out_ovf", out_ovf, (idx == 7) ? cur.ovf : 4'h0);
        for (int unsigned l = 0; l < 4; l++) got_word[l][idx] = out_bit[l];
        if (idx == 7) begin
          in_word = 0;
          last_word = got_word;
          last_ovf = out_ovf;
          words_out++;
        end
        idx++;
      end else begin
        check("idle_quiet", {out_valid, out_first, out_last, out_ovf}, 32'h0);
      end
    end
  end

  task automatic send_word(input logic [3:0][7:0] w, input logic [1:0] m,
                           input bit gap, input int unsigned nbits);
    for (int unsigned b = 0; b < nbits; b++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_first = (b == 0);
      mode = m;
      for (int unsigned l = 0; l < 4; l++) in_bit[l] = w[l][b];
      if (gap && b != nbits - 1) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
      end
    end
    if (nbits == 8) exp_q.push_back(model(w, m));
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_bit = '0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int unsigned c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_word && !out_valid) done = 1;
    end
    check(name, done, 1);
  endtask

  int unsigned w0;

  initial begin
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b0;
    repeat (2) @(posedge clk);

    // Negate 0x05 on lane 0, with direct latency check.
    w0 = words_out;
    send_word({8'h00, 8'h00, 8'h00, 8'h05}, 2'b01, 0, 8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    @(negedge clk);
    check("neg_latency", {out_valid, out_first}, 2'b11);
    drain("neg_drain");
    check("neg_words", words_out - w0, 1);
    check("neg_lane0", last_word[0], 8'hFB);
    check("neg_ovf", last_ovf, 4'h0);

    // Absolute value across all lanes, including the most-negative word.
    send_word({8'h80, 8'h00, 8'h0A, 8'hF6}, 2'b10, 0, 8);
    go_idle();
    drain("abs_drain");
    check("abs_word", last_word, {8'h80, 8'h00, 8'h0A, 8'h0A});
    check("abs_ovf", last_ovf, 4'b1000);

    // Pass then reserved mode, back to back.
    max_run = 0;
    w0 = words_out;
    send_word({8'h01, 8'h80, 8'h7F, 8'hA5}, 2'b00, 0, 8);
    send_word({8'h01, 8'h80, 8'h7F, 8'hA5}, 2'b11, 0, 8);
    go_idle();
    drain("pass_drain");
    check("pass_words", words_out - w0, 2);
    check("pass_lane0", last_word[0], 8'hA5);
    check("pass_ovf", last_ovf, 4'h0);
    check("b2b_run", max_run >= 16, 1);

    // Stray bit while idle, partial word, then a restart that must flag a framing error.
    w0 = fe_count;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_first = 1'b0;
    in_bit = 4'hF;
    go_idle();
    send_word({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 2'b01, 0, 4);
    send_word({8'h7F, 8'h81, 8'h33, 8'h05}, 2'b01, 0, 8);
    go_idle();
    drain("frame_drain");
    check("frame_err_count", fe_count - w0, 1);
    check("frame_word", last_word, {8'h81, 8'h7F, 8'hCD, 8'hFB});

    // Gapped input.
    send_word({8'h00, 8'h00, 8'h00, 8'h05}, 2'b01, 1, 8);
    go_idle();
    drain("gap_drain");
    check("gap_lane0", last_word[0], 8'hFB);

    // Reset during the 4th output bit.
    w0 = words_out;
    send_word({8'h13, 8'h13, 8'h13, 8'h13}, 2'b01, 0, 8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_no_word", words_out - w0, 0);
    send_word({8'h00, 8'h00, 8'h00, 8'h01}, 2'b01, 0, 8);
    go_idle();
    drain("rst_drain");
    check("rst_fresh", last_word[0], 8'hFF);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_negate_mc.md
# serial_negate_mc

Multi-channel, word-framed, bit-serial two's-complement unit. It replaces the single-bit fixed negator on the serial datapath. It accepts CHANNELS parallel LSB-first serial streams sharing one framing/valid qualifier. Per word it applies a latched mode: pass, negate, or absolute value, with overflow flagging. Each word is buffered once so that absolute value, which depends on the sign (the last bit received), can be applied on the output stream.

## Interface
- CHANNELS, 4, number of parallel serial lanes (≥1)
- WORD_W, 8, bits per word (≥2)
- clk  in  1  rising-edge clock
- n_reset  in  1  reset n_reset, synchronous, active-high
- in_valid  in  1  input bit qualifier; all lanes sampled together
- in_first  in  1  with in_valid: this bit is the LSB of a new word
- in_bit  in  CHANNELS  serial data, one bit per lane, LSB first
- mode  in  2  sampled with in_first: 00 pass, 01 negate, 10 abs, 11 treated as pass
- out_valid  out  1  output bit qualifier
- out_first  out  1  LSB of output word
- out_last  out  1  MSB of output word
- out_bit  out  CHANNELS  transformed serial data, LSB first
- out_ovf  out  CHANNELS  per-lane overflow, valid only with out_last
- frame_err  out  1  one-cycle pulse on a framing violation

## Operation
- Input side: bit counter `icnt` (0..WORD_W-1) advances only on in_valid.
  - in_valid with in_first: forces the bit to position 0 and latches mode.
  - in_valid without in_first while idle (no word in progress): bit dropped, no count.
- Word capture: each lane shifts its bit into a WORD_W input buffer.
  - On the edge accepting bit WORD_W-1, the full word (including that bit), the latched mode, and per-lane sign (= that bit) transfer to the output shift register.
  - `icnt` then returns to idle.
- Output side: emits WORD_W consecutive cycles with out_valid=1, independent of in_valid.
  - Per-lane transform flag: pass → never invert; negate → invert; abs → invert iff sign=1.
  - Invert rule, serial two's complement with per-lane `seen_one` cleared at word start: out_bit = data XOR (invert AND seen_one). `seen_one` sets after the first 1 bit is emitted.
  - out_ovf[i] = 1 at out_last iff invert and the word is 1000…0 (most-negative value). In that case the output equals the input.
- Framing error: in_first with in_valid while 1 ≤ icnt ≤ WORD_W-1.
  - frame_err pulses the next cycle.
  - The partial word is discarded with no output.
  - The new bit is taken as position 0 of a new word.
- Output never back-pressures. A word completes input no sooner than WORD_W cycles after the previous one, so the single output register suffices. A transfer arriving on the cycle the previous word emits its out_last is legal and chains seamlessly.

## Timing
- Reset (n_reset=1 at an edge): after the edge, all outputs are 0, icnt is idle, and buffers, mode, and seen_one are cleared.
  - Reset mid-word or mid-output drops all data; no partial output.
- Latency: the last input bit is accepted at edge E. out_first/out_valid are high in the cycle after E. out_last is high at cycle E+WORD_W.
- Back-to-back words with in_valid continuous: output is continuous, with out_valid never dropping between words.
- in_valid gaps inside an input word stretch input only; an output word already in flight is unaffected.
- out_ovf and out_last are asserted for exactly one cycle per word. out_first and out_last are both registered outputs.

## Structure
- Package `serial_negate_pkg`:
  - mode localparams MODE_PASS=2'b00, MODE_NEG=2'b01, MODE_ABS=2'b10;
  - typedef `mode_t` (2 bits);
  - function for the invert decision (mode, sign).
- Sub-module `serial_negate_lane`, instantiated CHANNELS times. It holds the input buffer, output shift register, sign, seen_one, and ovf tracking for one lane.
- Top level holds the shared icnt, output counter, latched mode, framing/error logic, and out_valid/out_first/out_last.

## Test plan
WORD_W=8, CHANNELS=4.
- Negate: lane0 = 0x05 (bits 1,0,1,0,0,0,0,0), mode=01 → out 1,1,0,1,1,1,1,1 (0xFB). out_first on the cycle after the 8th input edge; ovf=0.
- Abs: lanes = 0xF6, 0x0A, 0x00, 0x80, mode=10 → outputs 0x0A, 0x0A, 0x00, 0x80; out_ovf = 4'b1000 at out_last.
- Pass and reserved mode: 0xA5 with mode=00 and then 11 → 0xA5 both times, ovf=0. Back-to-back words give continuous out_valid for 16 cycles.
- Framing: in_first, 3 bits, then in_first again → frame_err pulses once, no output for the partial word, and the next full word is output correctly.
- Gapped input: 0x05 negate with in_valid low every other cycle → output 0xFB as 8 contiguous valid cycles after the last input bit.
- Reset: n_reset=1 during the 4th output bit → next cycle all outputs 0; after release, a fresh 0x01 negate yields 0xFF.
